// File: rtl/uart_fifo_tx.sv
// Transmit-side FIFO consumer: pops one byte per frame from the TX FIFO and
// serialises it as an 8N1 frame (start, data LSB first, stop) on the tx line.
module uart_fifo_tx #(
    parameter int data_bits      = 8,
    parameter int clocks_per_bit = 16,
    parameter int counter_width  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic [data_bits-1:0] fifo_data_out,
    input  logic                 fifo_empty_flag,
    output logic                 fifo_read_flag,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int INDEX_W = (data_bits > 1) ? $clog2(data_bits) : 1;
    localparam logic [counter_width-1:0] LAST_PERIOD = counter_width'(clocks_per_bit - 1);
    localparam logic [INDEX_W-1:0]       LAST_BIT    = INDEX_W'(data_bits - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    logic [counter_width-1:0] period;
    logic [INDEX_W-1:0]     bit_index;
    logic [data_bits-1:0]   shift_reg;

    logic                   period_end;
    logic [INDEX_W-1:0]     next_index;
    logic [counter_width-1:0] next_period;

    assign period_end  = (period == LAST_PERIOD);
    assign next_index  = bit_index + INDEX_W'(1);
    assign next_period = period + counter_width'(1);

    // The byte is latched at the start decision, so later changes on
    // fifo_data_out (including the post-pop head) never reach the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            period         <= '0;
            bit_index      <= '0;
            shift_reg      <= '0;
            fifo_read_flag <= 1'b0;
            tx             <= 1'b1;
            busy           <= 1'b0;
            tx_done        <= 1'b0;
        end else begin
            fifo_read_flag <= 1'b0;
            tx_done        <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_enable && !fifo_empty_flag) begin
                        shift_reg      <= fifo_data_out;
                        fifo_read_flag <= 1'b1;
                        tx             <= 1'b0;
                        busy           <= 1'b1;
                        period         <= '0;
                        state          <= START;
                    end
                end
                START: begin
                    if (period_end) begin
                        period    <= '0;
                        bit_index <= '0;
                        tx        <= shift_reg[0];
                        state     <= DATA;
                    end else begin
                        period <= next_period;
                    end
                end
                DATA: begin
                    if (period_end) begin
                        period <= '0;
                        if (bit_index == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_index <= next_index;
                            tx        <= shift_reg[next_index];
                        end
                    end else begin
                        period <= next_period;
                    end
                end
                STOP: begin
                    if (period_end) begin
                        // Returning to IDLE here costs one idle-high cycle
                        // before the next start decision.
                        period  <= '0;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        period <= next_period;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx with a 4-deep behavioural FIFO on its read side.
module tb_uart_fifo_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_enable = 1'b0;
    logic [7:0] fifo_data_out;
    logic       fifo_empty_flag;
    logic       fifo_read_flag;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [4];
    int   wr_count = 0;
    int   rd_count = 0;
    int   rd_while_empty = 0;
    int   cyc = 0;
    logic ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    assign fifo_empty_flag = (wr_count == rd_count);
    assign fifo_data_out   = ovr_en ? ovr_val : mem[rd_count % 4];

    uart_fifo_tx #(
        .data_bits      (8),
        .clocks_per_bit (4),
        .counter_width  (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .tx_enable       (tx_enable),
        .fifo_data_out   (fifo_data_out),
        .fifo_empty_flag (fifo_empty_flag),
        .fifo_read_flag  (fifo_read_flag),
        .tx              (tx),
        .busy            (busy),
        .tx_done         (tx_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (fifo_read_flag) begin
            if (fifo_empty_flag) rd_while_empty <= rd_while_empty + 1;
            else                 rd_count <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        if (wr_count - rd_count < 4) begin
            mem[wr_count % 4] = v;
            wr_count = wr_count + 1;
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_tx"}, tx, 1'b1);
            check({tag, "_busy"}, busy, 1'b0);
            check({tag, "_rd"}, fifo_read_flag, 1'b0);
            @(negedge clock);
        end
    endtask

    task automatic wait_start(input string tag, input int budget);
        int waited = 0;
        while (busy !== 1'b1 && waited < budget) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_start_seen"}, busy, 1'b1);
    endtask

    // Entered at the first negedge after the start edge; returns at the
    // negedge where tx_done should be high.
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int drop_at, input bit scramble);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int m = 0; m < 40; m++) begin
            check({tag, "_tx"}, tx, bits[m/4]);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_rd"}, fifo_read_flag, (m == 0) ? 1'b1 : 1'b0);
            check({tag, "_done"}, tx_done, 1'b0);
            if (m == drop_at) tx_enable = 1'b0;
            if (scramble) begin
                ovr_en  = 1'b1;
                ovr_val = 8'($urandom);
            end
            @(negedge clock);
        end
        ovr_en = 1'b0;
        check({tag, "_done_end"}, tx_done, 1'b1);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_tx_end"}, tx, 1'b1);
        check({tag, "_rd_end"}, fifo_read_flag, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start_cyc;
        int prev_cyc;
        logic [7:0] seq [4];
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;

        // Test 1: reset, then quiet with empty FIFO
        tx_enable = 1'b1;
        @(negedge clock);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", fifo_read_flag, 1'b0);
        check("rst_done", tx_done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        check_idle("empty_idle", 50);

        // Test 2: single byte 0xA5
        push(8'hA5);
        wait_start("a5", 5);
        start_cyc = cyc;
        check_frame("a5", 8'hA5, -1, 1'b0);
        check("a5_done_at_40", cyc - start_cyc, 40);
        check("a5_empty", fifo_empty_flag, 1'b1);
        check("a5_pops", rd_count, 1);

        // Test 3: four back-to-back bytes, FIFO full
        @(negedge clock);
        push(seq[0]); push(seq[1]); push(seq[2]); push(seq[3]);
        check("full_count", wr_count - rd_count, 4);
        prev_cyc = 0;
        for (int f = 0; f < 4; f++) begin
            wait_start("b2b", 5);
            if (f > 0) check("b2b_spacing", cyc - prev_cyc, 41);
            prev_cyc = cyc;
            check_frame("b2b", seq[f], -1, 1'b0);
        end
        check("b2b_empty", fifo_empty_flag, 1'b1);
        check("b2b_pops", rd_count, 5);

        // Test 4: enable gating and enable drop mid-frame
        @(negedge clock);
        tx_enable = 1'b0;
        push(8'h3C);
        push(8'h77);
        check_idle("disabled", 10);
        check("disabled_pops", rd_count, 5);
        tx_enable = 1'b1;
        @(negedge clock);
        check("enable_start", busy, 1'b1);
        check_frame("en_drop", 8'h3C, 16, 1'b0);
        @(negedge clock);
        check_idle("after_drop", 20);
        check("after_drop_pops", rd_count, 6);
        check("after_drop_nonempty", fifo_empty_flag, 1'b0);
        tx_enable = 1'b1;
        wait_start("x77", 5);
        check_frame("x77", 8'h77, -1, 1'b0);
        check("x77_pops", rd_count, 7);

        // Test 5: reset during data bit 2
        @(negedge clock);
        push(8'hFF);
        wait_start("ff", 5);
        for (int m = 0; m < 13; m++) @(negedge clock);
        check("ff_busy_pre", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("ff_rst_tx", tx, 1'b1);
        check("ff_rst_busy", busy, 1'b0);
        check("ff_rst_rd", fifo_read_flag, 1'b0);
        check("ff_rst_done", tx_done, 1'b0);
        for (int m = 0; m < 2; m++) begin
            @(negedge clock);
            check("ff_hold_done", tx_done, 1'b0);
            check("ff_hold_tx", tx, 1'b1);
        end
        reset = 1'b0;
        @(negedge clock);
        check_idle("ff_post", 20);
        check("ff_pops", rd_count, 8);
        check("ff_empty", fifo_empty_flag, 1'b1);

        // Test 6: data bus churning after the byte is latched
        push(8'h5A);
        wait_start("x5a", 5);
        check_frame("x5a", 8'h5A, -1, 1'b1);
        check("x5a_pops", rd_count, 9);
        check("rd_while_empty", rd_while_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- Transmit-side consumer for the UART FIFO.
- Drains bytes from a UART_fifo_interface instance through its read_flag/data_out/empty_flag side.
- Serialises each byte as an 8N1 UART frame on a single tx line, LSB first.
- Sits between the TX FIFO and the pad; the writer side of the FIFO is the producer (core or RX loopback).

Parameters:
- data_bits, 8, payload bits per frame; widths of fifo_data_out and the shift register.
- clocks_per_bit, 16, clock cycles per serial bit; minimum 2. The bench uses 4.
- counter_width, 8, width of the bit-period counter; must hold clocks_per_bit-1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_enable  input  1  level; when 0, no new frame is started (the frame in flight completes).
- fifo_data_out  input  data_bits  head-of-FIFO byte; valid whenever fifo_empty_flag=0.
- fifo_empty_flag  input  1  FIFO empty indication.
- fifo_read_flag  output  1  registered one-cycle pop strobe to the FIFO read_flag.
- tx  output  1  serial line; idle high.
- busy  output  1  high from frame start through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - tx=1, fifo_read_flag=0, busy=0, tx_done=0.
  - state=IDLE; bit counter, period counter and shift register cleared.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - At an edge where tx_enable=1 and fifo_empty_flag=0 (edge E0):
    - shift register <= fifo_data_out.
    - fifo_read_flag <= 1.
    - tx <= 0, busy <= 1, state <= START, period counter <= 0.
  - Otherwise stay in IDLE with tx=1.
- fifo_read_flag:
  - High for exactly the cycle following E0, so the FIFO pops at E0+1.
  - Never high in any other state.
  - Never asserted while fifo_empty_flag=1.
- START: tx=0 for clocks_per_bit cycles, then state DATA, bit index 0.
- DATA:
  - tx = shift register bit[index], LSB first.
  - Each bit is held exactly clocks_per_bit cycles.
  - Data bit i begins at E0+(1+i)*clocks_per_bit.
  - After bit data_bits-1, state STOP.
- STOP:
  - tx=1 for clocks_per_bit cycles, starting at E0+(1+data_bits)*clocks_per_bit.
  - At the edge ending the stop bit (E0+(2+data_bits)*clocks_per_bit): state IDLE, busy <= 0, tx_done <= 1 for one cycle.
- Back-to-back frames:
  - The next IDLE decision occurs one edge later.
  - The frame-to-frame period is exactly (data_bits+2)*clocks_per_bit+1 clocks, with one extra idle-high cycle between frames.
- Boundary conditions:
  - tx_enable falling mid-frame: current frame completes normally; no new read.
  - FIFO becoming empty mid-frame: no effect on the current frame; block idles afterwards.
  - FIFO full: no special handling; the FIFO's own write guard applies.
  - Reset mid-frame: tx returns high immediately. The byte already popped is discarded and is not re-read. No tx_done pulse.
  - fifo_data_out changing after E0: ignored, because the byte was latched at E0.
- Counters:
  - Period counter counts 0..clocks_per_bit-1 and wraps.
  - Bit index counts 0..data_bits-1.
  - No other arithmetic.

Test Plan:
1. Reset assertion/release with empty FIFO, clocks_per_bit=4 -> tx=1, busy=0, fifo_read_flag=0 for 50 cycles.
2. Write 0xA5 to FIFO (bits_depth=2), tx_enable=1:
   - Exactly one fifo_read_flag pulse.
   - tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   - tx_done pulse 40 cycles after E0; FIFO empty afterwards.
3. Write 0x01,0x02,0x03,0x04 (FIFO full):
   - Four frames, in order, with start edges exactly 41 cycles apart.
   - Four read pulses; FIFO empty_flag=1 after the fourth pop.
4. Load 0x3C, tx_enable=0 -> no read and tx idle. Raise tx_enable -> frame starts within 1 cycle. Drop tx_enable at data bit 3 -> frame completes; no further reads.
5. Start frame 0xFF, assert reset at data bit 2 -> tx=1 within the same cycle, busy=0, no tx_done. After release with FIFO empty -> stays idle.
6. Toggle fifo_data_out after E0 during a frame -> transmitted bits match the byte latched at E0.
